glb_bus_scheduler: RTL and testbench
====================================

# glb_bus_scheduler

Sequences one operand stream (ifmap, filter or psum) from a global buffer onto the X/Y multicast bus. It reads a contiguous word range from the GLB and attaches a raster-scan X_TAG/Y_TAG to each word. It drives the words onto the bus with a VALID/READY handshake and ends the stream with a one-cycle flush. One instance sits between each GLB bank and its BUS_CTRL.

## Interface
Parameters:
- DATA_WIDTH, 16, bus/GLB word width
- NUM_COL, 4, PE columns; X_TAG range
- NUM_ROW, 4, PE rows; Y_TAG range
- GLB_DEPTH, 1024, GLB words; AW = $clog2(GLB_DEPTH)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; accepted only in IDLE
- abort  in  1  synchronous cancel, any state
- base_addr  in  AW  first GLB address
- len  in  AW+1  words to send (0..GLB_DEPTH)
- cols_cfg  in  $clog2(NUM_COL)+1  active columns; 0 or >NUM_COL means NUM_COL
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- glb_en  out  1  GLB read enable
- glb_addr  out  AW  GLB read address
- glb_dout  in  DATA_WIDTH  read data, valid exactly 1 cycle after glb_en
- bus_data  out  DATA_WIDTH  word to bus
- bus_x_tag  out  $clog2(NUM_COL)  column tag
- bus_y_tag  out  $clog2(NUM_ROW)  row tag
- bus_valid  out  1  bus word valid
- bus_ready  in  1  bus accepts word
- flush  out  1  end-of-stream marker to bus

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: start=1 captures base_addr, len and the clamped cols_cfg.
  - If len=0: go to FLUSH.
  - Otherwise: go to RUN and reset issue count, x_tag and y_tag to 0.
  - start in RUN or FLUSH is ignored.
- RUN, issue side:
  - Assert glb_en with glb_addr = (base_addr + k) mod GLB_DEPTH while k < len and occupancy + in_flight − pop_this_cycle < 2.
  - The tag pair is computed at issue time and travels with the read.
  - After each issue, x_tag increments. At cols_cfg−1 it wraps to 0 and y_tag increments.
  - y_tag wraps from NUM_ROW−1 to 0.
- RUN, return side:
  - glb_dout and its tags are written into a 2-entry FIFO the cycle after glb_en.
  - bus_valid = FIFO non-empty; bus_data and tags come from the FIFO head.
  - A transfer happens on bus_valid & bus_ready.
  - bus_data and tags hold stable while bus_valid=1 and bus_ready=0.
- Leaving RUN: the cycle that transfers word len−1 moves the state to FLUSH.
- FLUSH: flush=1 and done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN and FLUSH.
- abort=1: next state IDLE.
  - FIFO is emptied and in-flight read data is discarded.
  - No flush, no done.
  - abort takes priority over start and over the transfer.
- rst mid-job: same effect as abort, but asynchronous.

## Timing
- Reset values: busy=0, done=0, glb_en=0, glb_addr=0, bus_valid=0, bus_data=0, bus_x_tag=0, bus_y_tag=0, flush=0. State=IDLE, FIFO empty.
- Latency, with start sampled at edge T:
  - First glb_en in cycle T+1.
  - First bus_valid in cycle T+3.
- Throughput: with bus_ready held at 1, one word per cycle, no bubbles.
- Completion: last transfer in cycle P gives flush=done=1 in P+1 and busy=0 from P+2.
- Backpressure:
  - At most 2 words are buffered or in flight.
  - glb_en stays low while that credit is exhausted.
  - No word is lost or duplicated.
- Address wrap: base_addr=GLB_DEPTH−2, len=4 reads 1022, 1023, 0, 1.
- Simultaneous events: in the same cycle, a pop and an issue are both legal, and so are a FIFO write and a FIFO read.
- len=0: FLUSH is entered at T+1 and no glb_en is ever asserted.

## Structure
- Shared package bus_sched_pkg holds:
  - the state enum (IDLE, RUN, FLUSH);
  - a tagged-word struct {data, x_tag, y_tag} parameterised by widths through localparams;
  - a clamp function for cols_cfg.
- Sub-module fifo2_tagged: 2-entry FIFO of the tagged-word struct with push/pop/empty/full and simultaneous push+pop.
- Top level holds the FSM, issue counter, address adder, tag counters and in-flight flag.

## Test plan
- base_addr=10, len=6, cols_cfg=3, bus_ready=1:
  - glb_addr 10..15 in T+1..T+6;
  - tags (x,y) = (0,0)(1,0)(2,0)(0,1)(1,1)(2,1);
  - 6 back-to-back transfers from T+3;
  - flush=done=1 at T+9.
- Same job with bus_ready toggling 1,0,0,1 repeatedly:
  - all 6 words arrive in order;
  - bus_data and tags are stable while stalled;
  - glb_en never runs more than 2 ahead of the pops.
- base_addr=1022, len=4, cols_cfg=0: addresses 1022, 1023, 0, 1; x_tag 0,1,2,3; y_tag 0.
- len=0: no glb_en, no bus_valid; flush=done=1 at T+1.
- abort asserted after 2 transfers of len=8:
  - IDLE next cycle;
  - bus_valid=0 and no flush/done;
  - a new start then runs normally from x_tag=0, y_tag=0.
- rst pulse mid-job with bus_ready=0:
  - all outputs return immediately to reset values;
  - start pulsed during RUN of a separate job is ignored.

Source files
------------

// File: rtl/glb_bus_scheduler_pkg.sv
// Shared types for the GLB-to-bus scheduler: FSM states, the tagged bus word
// and the active-column clamp.
package bus_sched_pkg;

  localparam int TW_DATA_W = 16;
  localparam int TW_NUM_COL = 4;
  localparam int TW_NUM_ROW = 4;
  localparam int TW_X_W = $clog2(TW_NUM_COL);
  localparam int TW_Y_W = $clog2(TW_NUM_ROW);
  localparam int TW_C_W = TW_X_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [TW_DATA_W-1:0] data;
    logic [TW_X_W-1:0]    x_tag;
    logic [TW_Y_W-1:0]    y_tag;
  } tword_t;

  // Zero or an out-of-range request means "use every column".
  function automatic logic [TW_C_W-1:0] clamp_cols(input logic [TW_C_W-1:0] cfg,
                                                    input int unsigned     num_col);
    if (cfg == '0 || cfg > TW_C_W'(num_col)) return TW_C_W'(num_col);
    return cfg;
  endfunction

endpackage

// File: rtl/glb_bus_scheduler_if.sv
// Job control, GLB read port and tagged bus port of one scheduler instance.
interface glb_bus_scheduler_if #(
  parameter int GLB_DEPTH = 1024
);
  import bus_sched_pkg::*;

  localparam int AW = $clog2(GLB_DEPTH);

  logic                 start;
  logic                 abort;
  logic [AW-1:0]        base_addr;
  logic [AW:0]          len;
  logic [TW_C_W-1:0]    cols_cfg;
  logic                 busy;
  logic                 done;
  logic                 glb_en;
  logic [AW-1:0]        glb_addr;
  logic [TW_DATA_W-1:0] glb_dout;
  logic [TW_DATA_W-1:0] bus_data;
  logic [TW_X_W-1:0]    bus_x_tag;
  logic [TW_Y_W-1:0]    bus_y_tag;
  logic                 bus_valid;
  logic                 bus_ready;
  logic                 flush;

  modport slave (
    input  start, abort, base_addr, len, cols_cfg, glb_dout, bus_ready,
    output busy, done, glb_en, glb_addr, bus_data, bus_x_tag, bus_y_tag,
           bus_valid, flush
  );

  modport master (
    output start, abort, base_addr, len, cols_cfg, glb_dout, bus_ready,
    input  busy, done, glb_en, glb_addr, bus_data, bus_x_tag, bus_y_tag,
           bus_valid, flush
  );

endinterface

// File: rtl/glb_bus_scheduler_fifo.sv
// Two-entry FIFO of tagged words; push and pop may happen in the same cycle.
module fifo2_tagged
  import bus_sched_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_clear,
  input  logic   i_push,
  input  tword_t i_din,
  input  logic   i_pop,
  output tword_t o_head,
  output logic   o_empty,
  output logic   o_full
);

  tword_t     r_mem [2];
  logic       r_wr;
  logic       r_rd;
  logic [1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clear) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/glb_bus_scheduler.sv
// Streams a contiguous GLB word range onto the X/Y multicast bus with
// raster-scan tags, a 2-word credit window and a closing flush pulse.
module glb_bus_scheduler
  import bus_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int NUM_ROW    = 4,
  parameter int GLB_DEPTH  = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst,
  glb_bus_scheduler_if.slave s_if
);

  localparam int AW = $clog2(GLB_DEPTH);
  localparam int XW = $clog2(NUM_COL);
  localparam int YW = $clog2(NUM_ROW);
  localparam int CW = XW + 1;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_base;
  logic [AW:0]     r_len;
  logic [AW:0]     r_issue_cnt;
  logic [AW:0]     r_pop_cnt;
  logic [CW-1:0]   r_cols;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [XW-1:0]   r_fl_x;
  logic [YW-1:0]   r_fl_y;
  logic            r_inflight;

  logic            w_accept;
  logic            w_issue;
  logic            w_pop;
  logic            w_push;
  logic            w_credit_ok;
  logic            w_last_pop;
  logic            w_empty;
  logic            w_full;
  logic [AW:0]     w_sum;
  logic [DATA_WIDTH-1:0] w_rdata;
  tword_t          w_din;
  tword_t          w_head;

  assign w_accept = (r_state == IDLE) & s_if.start & ~s_if.abort;
  assign w_pop    = ~w_empty & s_if.bus_ready & ~s_if.abort;
  assign w_push   = r_inflight & ~s_if.abort;

  // occupancy + in_flight - pop < 2, written with the FIFO flags
  assign w_credit_ok = w_empty | (w_full & w_pop) | (~w_full & (~r_inflight | w_pop));

  assign w_issue    = (r_state == RUN) & ~s_if.abort & (r_issue_cnt < r_len) & w_credit_ok;
  assign w_last_pop = w_pop & (r_pop_cnt == r_len - (AW+1)'(1));

  assign w_sum = {1'b0, r_base} + r_issue_cnt;
  assign s_if.glb_addr = (w_sum >= (AW+1)'(GLB_DEPTH)) ?
                         AW'(w_sum - (AW+1)'(GLB_DEPTH)) : w_sum[AW-1:0];
  assign s_if.glb_en = w_issue;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    s_if.busy   = 1'b0;
    s_if.done   = 1'b0;
    s_if.flush  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = (s_if.len == '0) ? FLUSH : RUN;
      end
      RUN: begin
        s_if.busy = 1'b1;
        if (w_last_pop) w_next = FLUSH;
      end
      FLUSH: begin
        s_if.busy  = 1'b1;
        s_if.done  = 1'b1;
        s_if.flush = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (s_if.abort) w_next = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_base      <= '0;
      r_len       <= '0;
      r_cols      <= '0;
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_fl_x      <= '0;
      r_fl_y      <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fl_x <= r_x;
        r_fl_y <= r_y;
      end
      if (w_accept) begin
        r_base      <= s_if.base_addr;
        r_len       <= s_if.len;
        r_cols      <= clamp_cols(s_if.cols_cfg, NUM_COL);
        r_issue_cnt <= '0;
        r_pop_cnt   <= '0;
        r_x         <= '0;
        r_y         <= '0;
      end else begin
        if (w_issue) begin
          r_issue_cnt <= r_issue_cnt + (AW+1)'(1);
          if ({1'b0, r_x} == r_cols - CW'(1)) begin
            r_x <= '0;
            r_y <= (r_y == YW'(NUM_ROW - 1)) ? '0 : r_y + YW'(1);
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
        if (w_pop) r_pop_cnt <= r_pop_cnt + (AW+1)'(1);
      end
    end
  end

  assign w_rdata = s_if.glb_dout;
  always_comb begin
    w_din       = '0;
    w_din.data  = w_rdata;
    w_din.x_tag = r_fl_x;
    w_din.y_tag = r_fl_y;
  end

  fifo2_tagged u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (s_if.abort),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign s_if.bus_valid = ~w_empty;
  assign s_if.bus_data  = w_head.data;
  assign s_if.bus_x_tag = w_head.x_tag;
  assign s_if.bus_y_tag = w_head.y_tag;

endmodule

// File: tb/tb_glb_bus_scheduler.sv
// Randomised bench for glb_bus_scheduler against a word-list reference model.
module tb_glb_bus_scheduler;

  localparam int DEPTH = 1024;
  localparam int NCOL  = 4;
  localparam int NROW  = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [15:0] mem [DEPTH];

  glb_bus_scheduler_if #(.GLB_DEPTH(DEPTH)) bif ();

  glb_bus_scheduler #(
    .DATA_WIDTH (16),
    .NUM_COL    (NCOL),
    .NUM_ROW    (NROW),
    .GLB_DEPTH  (DEPTH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .s_if  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GLB: read data valid the cycle after the enable
  always @(posedge clk) if (bif.glb_en) bif.glb_dout <= mem[bif.glb_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rdy(input int mode, input int n);
    case (mode)
      0: return 1'b1;
      1: return (n % 4 == 0) || (n % 4 == 3);
      2: return 1'(($urandom % 3) != 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(bif.busy), 0);
    chk({tag, "_done"},  32'(bif.done), 0);
    chk({tag, "_en"},    32'(bif.glb_en), 0);
    chk({tag, "_addr"},  32'(bif.glb_addr), 0);
    chk({tag, "_valid"}, 32'(bif.bus_valid), 0);
    chk({tag, "_data"},  32'(bif.bus_data), 0);
    chk({tag, "_x"},     32'(bif.bus_x_tag), 0);
    chk({tag, "_y"},     32'(bif.bus_y_tag), 0);
    chk({tag, "_flush"}, 32'(bif.flush), 0);
  endtask

  // Runs one job; cycle n is the n-th cycle after the edge that samples start.
  task automatic run_job(input int base, input int len, input int cols, input int mode,
                         input int abort_after, input int restart_n, input int rst_at_n,
                         input int exp_flush_n);
    int ce, iss, pops, last_pop_n, abort_state;
    logic stalled, finished, flushed;
    logic [15:0] p_data;
    logic [1:0]  p_x, p_y;
    int k;
    ce = (cols == 0 || cols > NCOL) ? NCOL : cols;
    iss = 0; pops = 0; last_pop_n = 0; abort_state = 0;
    stalled = 0; finished = 0; flushed = 0;
    p_data = '0; p_x = '0; p_y = '0;

    @(posedge clk); #1;
    bif.start     = 1'b1;
    bif.base_addr = 10'(base);
    bif.len       = 11'(len);
    bif.cols_cfg  = 3'(cols);
    bif.bus_ready = rdy(mode, 0);

    for (int n = 1; n <= 600 && !finished; n++) begin
      @(posedge clk); #1;
      bif.start     = (n == restart_n);
      if (n == restart_n) begin
        bif.base_addr = 10'($urandom);
        bif.len       = 11'($urandom_range(1, 5));
        bif.cols_cfg  = 3'($urandom);
      end
      bif.bus_ready = rdy(mode, n);
      if (abort_state == 1) begin
        bif.abort = 1'b1;
        abort_state = 2;
        continue;
      end
      if (abort_state == 2) bif.abort = 1'b0;
      @(negedge clk);

      if (abort_state == 2) begin
        chk("abort_busy",  32'(bif.busy), 0);
        chk("abort_valid", 32'(bif.bus_valid), 0);
        chk("abort_flush", 32'(bif.flush), 0);
        chk("abort_done",  32'(bif.done), 0);
        finished = 1;
        continue;
      end
      if (flushed) begin
        chk("post_busy", 32'(bif.busy), 0);
        chk("post_done", 32'(bif.done), 0);
        finished = 1;
        continue;
      end
      if (n == 1) begin
        chk("busy_t1", 32'(bif.busy), 1);
        chk("en_t1", 32'(bif.glb_en), 32'(len > 0));
      end
      if (n == 3 && len > 0) chk("valid_t3", 32'(bif.bus_valid), 1);

      if (bif.glb_en) begin
        k = (base + iss) % DEPTH;
        chk("glb_addr", 32'(bif.glb_addr), 32'(k));
        iss++;
      end

      if (bif.bus_valid) begin
        if (stalled) begin
          chk("stall_data", 32'(bif.bus_data), 32'(p_data));
          chk("stall_x",    32'(bif.bus_x_tag), 32'(p_x));
          chk("stall_y",    32'(bif.bus_y_tag), 32'(p_y));
        end
        if (bif.bus_ready) begin
          if (pops < len) begin
            chk("data",  32'(bif.bus_data),  32'(mem[(base + pops) % DEPTH]));
            chk("x_tag", 32'(bif.bus_x_tag), 32'(pops % ce));
            chk("y_tag", 32'(bif.bus_y_tag), 32'((pops / ce) % NROW));
          end else begin
            chk("extra_word", 32'(pops), 32'(len - 1));
          end
          pops++;
          last_pop_n = n;
        end
        stalled = !bif.bus_ready;
        p_data = bif.bus_data; p_x = bif.bus_x_tag; p_y = bif.bus_y_tag;
      end else begin
        stalled = 0;
      end
      chk("credit", 32'((iss - pops) <= 2), 1);

      if (bif.flush) begin
        chk("flush_done", 32'(bif.done), 1);
        chk("flush_words", 32'(pops), 32'(len));
        chk("flush_issues", 32'(iss), 32'(len));
        chk("flush_cycle", 32'(n), 32'((len > 0) ? last_pop_n + 1 : 1));
        if (exp_flush_n > 0) chk("flush_abs", 32'(n), 32'(exp_flush_n));
        flushed = 1;
      end

      if (abort_after >= 0 && pops == abort_after && abort_state == 0) abort_state = 1;

      if (n == rst_at_n) begin
        chk("pre_rst_valid", 32'(bif.bus_valid), 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        finished = 1;
      end
    end
    bif.start = 1'b0;
    bif.abort = 1'b0;
    chk("job_terminated", 32'(finished), 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    rst           = 1'b1;
    bif.start     = 1'b0;
    bif.abort     = 1'b0;
    bif.base_addr = '0;
    bif.len       = '0;
    bif.cols_cfg  = '0;
    bif.bus_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    run_job(10, 6, 3, 0, -1, 0, 0, 9);
    run_job(10, 6, 3, 1, -1, 0, 0, 0);
    run_job(1022, 4, 0, 0, -1, 0, 0, 7);
    run_job(500, 0, 2, 0, -1, 0, 0, 1);
    run_job(100, 8, 2, 0, 2, 0, 0, 0);
    run_job(200, 5, 3, 0, -1, 0, 0, 0);
    run_job(50, 8, 4, 3, -1, 0, 5, 0);
    run_job(300, 10, 4, 2, -1, 4, 0, 0);
    for (int j = 0; j < 20; j++)
      run_job(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 24)),
              int'($urandom_range(0, 7)), 2, -1, 0, 0, 0);
    run_job(1020, 9, 5, 1, -1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
